// File: rtl/common_types_pkg.sv
// rtl/common_types_pkg.sv - shared cause codes, mtvec modes, trap FSM state and cause lookup
package common_types_pkg;

    localparam logic [31:0] EXC_BREAKPOINT     = 32'd3;
    localparam logic [31:0] EXC_INST_MISALIGN  = 32'd0;
    localparam logic [31:0] EXC_ILLEGAL        = 32'd2;
    localparam logic [31:0] EXC_ECALL_M        = 32'd11;
    localparam logic [31:0] EXC_LOAD_MISALIGN  = 32'd4;
    localparam logic [31:0] EXC_STORE_MISALIGN = 32'd6;

    localparam logic [1:0] MTVEC_DIRECT   = 2'b00;
    localparam logic [1:0] MTVEC_VECTORED = 2'b01;

    typedef enum logic [1:0] {
        IDLE,
        TRAP,
        HOLD
    } trap_state_t;

    // Maps an exc_req bit index to its mcause code.
    function automatic logic [31:0] exc_cause(input logic [2:0] idx);
        case (idx)
            3'd0:    exc_cause = EXC_BREAKPOINT;
            3'd1:    exc_cause = EXC_INST_MISALIGN;
            3'd2:    exc_cause = EXC_ILLEGAL;
            3'd3:    exc_cause = EXC_ECALL_M;
            3'd4:    exc_cause = EXC_LOAD_MISALIGN;
            3'd5:    exc_cause = EXC_STORE_MISALIGN;
            default: exc_cause = EXC_BREAKPOINT;
        endcase
    endfunction

endpackage

// File: rtl/trap_controller_if.sv
// rtl/trap_controller_if.sv - signal bundle for trap_controller (everything except CLK and RST)
interface trap_controller_if #(
    parameter int NUM_IRQ = 4
);
    logic               e2m_valid;
    logic [31:0]        e2m_pc;
    logic [5:0]         exc_req;
    logic [NUM_IRQ-1:0] irq_in;
    logic [NUM_IRQ-1:0] irq_en;
    logic               interrupt_en;
    logic [1:0]         mtvec_mode;
    logic [31:0]        mtvec_base;
    logic               trap;
    logic               is_interrupt;
    logic [31:0]        trap_pc;
    logic [31:0]        trap_cause;
    logic [31:0]        trap_target;
    logic               f2d_flush;
    logic               d2e_flush;
    logic               e2m_flush;
    logic               m2w_flush;
    logic               busy;
    logic [NUM_IRQ-1:0] irq_pending;

    modport trap_controller (
        input  e2m_valid, e2m_pc, exc_req, irq_in, irq_en, interrupt_en, mtvec_mode, mtvec_base,
        output trap, is_interrupt, trap_pc, trap_cause, trap_target,
               f2d_flush, d2e_flush, e2m_flush, m2w_flush, busy, irq_pending
    );

    modport tb (
        output e2m_valid, e2m_pc, exc_req, irq_in, irq_en, interrupt_en, mtvec_mode, mtvec_base,
        input  trap, is_interrupt, trap_pc, trap_cause, trap_target,
               f2d_flush, d2e_flush, e2m_flush, m2w_flush, busy, irq_pending
    );
endinterface

// File: rtl/irq_sync.sv
// rtl/irq_sync.sv - per-line irq synchroniser with optional sticky edge latch (TRAP_CONTROLLER_IRQ_EDGE_EN)
module irq_sync #(
    parameter int NUM_IRQ     = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_IRQ-1:0] irq_in,
    input  logic [NUM_IRQ-1:0] clr,
    output logic [NUM_IRQ-1:0] pending
);

    logic [NUM_IRQ-1:0] synced;

    generate
        if (SYNC_STAGES == 0) begin : g_bypass
            assign synced = irq_in;
        end else begin : g_sync
            logic [SYNC_STAGES-1:0][NUM_IRQ-1:0] stage;

            // Shift the raw lines through SYNC_STAGES flops to settle metastability.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    stage <= '0;
                end else begin
                    stage[0] <= irq_in;
                    for (int s = 1; s < SYNC_STAGES; s++) begin
                        stage[s] <= stage[s-1];
                    end
                end
            end

            assign synced = stage[SYNC_STAGES-1];
        end
    endgenerate

`ifdef TRAP_CONTROLLER_IRQ_EDGE_EN
    logic [NUM_IRQ-1:0] prev;
    logic [NUM_IRQ-1:0] sticky;

    // Latch rising edges; a new edge outranks a clear landing in the same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev   <= '0;
            sticky <= '0;
        end else begin
            prev   <= synced;
            sticky <= (sticky & ~clr) | (synced & ~prev);
        end
    end

    assign pending = sticky;
`else
    logic unused_clr;
    assign unused_clr = ^clr;
    assign pending    = synced;
`endif

endmodule

// File: rtl/trap_controller.sv
// rtl/trap_controller.sv - fixed-priority exception/interrupt arbiter, mtvec target and flush sequencer (edge irq option: TRAP_CONTROLLER_IRQ_EDGE_EN)
module trap_controller
    import common_types_pkg::*;
#(
    parameter int NUM_IRQ        = 4,
    parameter int SYNC_STAGES    = 2,
    parameter int FLUSH_CYCLES   = 2,
    parameter int IRQ_CAUSE_BASE = 16
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               e2m_valid,
    input  logic [31:0]        e2m_pc,
    input  logic [5:0]         exc_req,
    input  logic [NUM_IRQ-1:0] irq_in,
    input  logic [NUM_IRQ-1:0] irq_en,
    input  logic               interrupt_en,
    input  logic [1:0]         mtvec_mode,
    input  logic [31:0]        mtvec_base,
    output logic               trap,
    output logic               is_interrupt,
    output logic [31:0]        trap_pc,
    output logic [31:0]        trap_cause,
    output logic [31:0]        trap_target,
    output logic               f2d_flush,
    output logic               d2e_flush,
    output logic               e2m_flush,
    output logic               m2w_flush,
    output logic               busy,
    output logic [NUM_IRQ-1:0] irq_pending
);

    localparam int CW = $clog2(FLUSH_CYCLES + 1);

    trap_state_t        state;
    logic [CW-1:0]      cnt;
    logic               flush;
    logic [NUM_IRQ-1:0] taken_line;
    logic [NUM_IRQ-1:0] irq_clr;

    logic               exc_hit;
    logic [2:0]         exc_idx;
    logic [NUM_IRQ-1:0] irq_masked;
    logic               irq_hit;
    logic [3:0]         irq_idx;
    logic [NUM_IRQ-1:0] irq_onehot;
    logic [31:0]        irq_cause;
    logic               take_exc;
    logic               take_irq;
    logic [31:0]        next_cause;
    logic [31:0]        next_target;

    irq_sync #(
        .NUM_IRQ     (NUM_IRQ),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_irq_sync (
        .clk     (CLK),
        .rst     (RST),
        .irq_in  (irq_in),
        .clr     (irq_clr),
        .pending (irq_pending)
    );

    // The interrupt just taken drops its sticky pending bit during the TRAP cycle.
    assign irq_clr = (state == TRAP && is_interrupt) ? taken_line : '0;

    // Priority pick (lowest index wins), cause and redirect target for a potential take.
    always_comb begin
        exc_hit = |exc_req;
        exc_idx = 3'd0;
        for (int i = 5; i >= 0; i--) begin
            if (exc_req[i]) exc_idx = 3'(i);
        end

        irq_masked = irq_pending & irq_en;
        irq_hit    = interrupt_en && (|irq_masked);
        irq_idx    = 4'd0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (irq_masked[i]) irq_idx = 4'(i);
        end
        irq_onehot = NUM_IRQ'(1) << irq_idx;
        irq_cause  = {1'b1, 31'(IRQ_CAUSE_BASE) + 31'(irq_idx)};

        take_exc = (state == IDLE) && e2m_valid && exc_hit;
        take_irq = (state == IDLE) && e2m_valid && !exc_hit && irq_hit;

        next_cause  = take_exc ? exc_cause(exc_idx) : irq_cause;
        next_target = mtvec_base;
        if (!take_exc && mtvec_mode == MTVEC_VECTORED) begin
            next_target = mtvec_base + {next_cause[29:0], 2'b00};
        end
    end

    // Trap FSM: IDLE takes a request, TRAP pulses trap, HOLD stretches the flush.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state        <= IDLE;
            cnt          <= '0;
            trap         <= 1'b0;
            flush        <= 1'b0;
            busy         <= 1'b0;
            is_interrupt <= 1'b0;
            trap_pc      <= '0;
            trap_cause   <= '0;
            trap_target  <= '0;
            taken_line   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (take_exc || take_irq) begin
                        state        <= TRAP;
                        trap         <= 1'b1;
                        flush        <= 1'b1;
                        busy         <= 1'b1;
                        is_interrupt <= take_irq;
                        trap_pc      <= e2m_pc;
                        trap_cause   <= next_cause;
                        trap_target  <= next_target;
                        taken_line   <= take_irq ? irq_onehot : '0;
                    end
                end
                TRAP: begin
                    trap <= 1'b0;
                    if (FLUSH_CYCLES > 1) begin
                        state <= HOLD;
                        cnt   <= CW'(1);
                    end else begin
                        state <= IDLE;
                        flush <= 1'b0;
                        busy  <= 1'b0;
                    end
                end
                HOLD: begin
                    if (cnt == CW'(FLUSH_CYCLES - 1)) begin
                        state <= IDLE;
                        flush <= 1'b0;
                        busy  <= 1'b0;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    flush <= 1'b0;
                    busy  <= 1'b0;
                    trap  <= 1'b0;
                end
            endcase
        end
    end

    assign f2d_flush = flush;
    assign d2e_flush = flush;
    assign e2m_flush = flush;
    assign m2w_flush = flush;

endmodule

// File: tb/tb_trap_controller.sv
// tb/tb_trap_controller.sv - directed self-checking bench for trap_controller
module tb_trap_controller;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;

    trap_controller_if #(.NUM_IRQ(4)) tif ();

    trap_controller #(
        .NUM_IRQ        (4),
        .SYNC_STAGES    (2),
        .FLUSH_CYCLES   (2),
        .IRQ_CAUSE_BASE (16)
    ) dut (
        .CLK          (CLK),
        .RST          (RST),
        .e2m_valid    (tif.e2m_valid),
        .e2m_pc       (tif.e2m_pc),
        .exc_req      (tif.exc_req),
        .irq_in       (tif.irq_in),
        .irq_en       (tif.irq_en),
        .interrupt_en (tif.interrupt_en),
        .mtvec_mode   (tif.mtvec_mode),
        .mtvec_base   (tif.mtvec_base),
        .trap         (tif.trap),
        .is_interrupt (tif.is_interrupt),
        .trap_pc      (tif.trap_pc),
        .trap_cause   (tif.trap_cause),
        .trap_target  (tif.trap_target),
        .f2d_flush    (tif.f2d_flush),
        .d2e_flush    (tif.d2e_flush),
        .e2m_flush    (tif.e2m_flush),
        .m2w_flush    (tif.m2w_flush),
        .busy         (tif.busy),
        .irq_pending  (tif.irq_pending)
    );

    logic [3:0] flushes;
    assign flushes = {tif.f2d_flush, tif.d2e_flush, tif.e2m_flush, tif.m2w_flush};

    always #5 CLK = ~CLK;

    task automatic tick(input int n);
        for (int k = 0; k < n; k++) @(negedge CLK);
    endtask

    task automatic test_reset;
        tif.e2m_valid = 0; tif.e2m_pc = 0; tif.exc_req = 0; tif.irq_in = 0; tif.irq_en = 0;
        tif.interrupt_en = 0; tif.mtvec_mode = 2'b01; tif.mtvec_base = 32'h800;
        RST = 1'b1;
        tick(2);
        n_checks++;
        if ({tif.trap, tif.busy, tif.is_interrupt, flushes} !== 7'b0) begin
            n_fail++; $display("FAIL reset_ctrl: got %b want 0", {tif.trap, tif.busy, tif.is_interrupt, flushes});
        end
        n_checks++;
        if ({tif.trap_pc, tif.trap_cause, tif.trap_target} !== 96'b0) begin
            n_fail++; $display("FAIL reset_regs: got %h %h %h want 0", tif.trap_pc, tif.trap_cause, tif.trap_target);
        end
        n_checks++;
        if (tif.irq_pending !== 4'b0) begin
            n_fail++; $display("FAIL reset_pending: got %b want 0000", tif.irq_pending);
        end
        RST = 1'b0;
        tick(1);
    endtask

    task automatic test_exception;
        tif.e2m_valid = 1; tif.exc_req = 6'b000100; tif.e2m_pc = 32'h100;
        tif.mtvec_mode = 2'b01; tif.mtvec_base = 32'h800;
        tick(1);
        n_checks++;
        if ({tif.trap, tif.is_interrupt, tif.busy} !== 3'b101 || flushes !== 4'hF) begin
            n_fail++; $display("FAIL exc_pulse: got trap/int/busy=%b flush=%b want 101 1111", {tif.trap, tif.is_interrupt, tif.busy}, flushes);
        end
        n_checks++;
        if (tif.trap_cause !== 32'd2 || tif.trap_pc !== 32'h100 || tif.trap_target !== 32'h800) begin
            n_fail++; $display("FAIL exc_regs: got cause=%h pc=%h tgt=%h want 2 100 800", tif.trap_cause, tif.trap_pc, tif.trap_target);
        end
        tif.e2m_valid = 0; tif.exc_req = 0;
        tick(1);
        n_checks++;
        if (tif.trap !== 1'b0 || flushes !== 4'hF || tif.busy !== 1'b1) begin
            n_fail++; $display("FAIL exc_hold: got trap=%b flush=%b busy=%b want 0 1111 1", tif.trap, flushes, tif.busy);
        end
        tick(1);
        n_checks++;
        if (flushes !== 4'h0 || tif.busy !== 1'b0 || tif.trap_cause !== 32'd2) begin
            n_fail++; $display("FAIL exc_done: got flush=%b busy=%b cause=%h want 0000 0 2", flushes, tif.busy, tif.trap_cause);
        end
    endtask

    task automatic test_exc_priority;
        logic [5:0]  reqs   [5] = '{6'b110000, 6'b100000, 6'b000010, 6'b101000, 6'b111111};
        logic [31:0] causes [5] = '{32'd4, 32'd6, 32'd0, 32'd11, 32'd3};
        for (int i = 0; i < 5; i++) begin
            tif.e2m_valid = 1; tif.exc_req = reqs[i]; tif.e2m_pc = 32'h1000 + 32'(i * 4);
            tick(1);
            n_checks++;
            if (tif.trap !== 1'b1 || tif.trap_cause !== causes[i] || tif.is_interrupt !== 1'b0 ||
                tif.trap_target !== 32'h800 || tif.trap_pc !== 32'h1000 + 32'(i * 4)) begin
                n_fail++; $display("FAIL exc_prio[%0d]: got trap=%b cause=%h tgt=%h pc=%h want 1 %h 800 %h",
                                   i, tif.trap, tif.trap_cause, tif.trap_target, tif.trap_pc, causes[i], 32'h1000 + 32'(i * 4));
            end
            tif.e2m_valid = 0; tif.exc_req = 0;
            tick(2);
        end
    endtask

    task automatic test_irq_level;
        tif.irq_in = 4'b1000; tif.irq_en = 4'hF; tif.interrupt_en = 1; tif.e2m_valid = 1;
        tif.e2m_pc = 32'h400; tif.mtvec_mode = 2'b01; tif.mtvec_base = 32'h800;
        tick(2);
        n_checks++;
        if (tif.trap !== 1'b0 || tif.irq_pending !== 4'b1000) begin
            n_fail++; $display("FAIL irq_sync_delay: got trap=%b pending=%b want 0 1000", tif.trap, tif.irq_pending);
        end
        tick(1);
        n_checks++;
        if (tif.trap !== 1'b1 || tif.is_interrupt !== 1'b1 || tif.trap_cause !== 32'h80000013 ||
            tif.trap_target !== 32'h84C || tif.trap_pc !== 32'h400) begin
            n_fail++; $display("FAIL irq_take: got trap=%b int=%b cause=%h tgt=%h pc=%h want 1 1 80000013 84c 400",
                               tif.trap, tif.is_interrupt, tif.trap_cause, tif.trap_target, tif.trap_pc);
        end
        tif.irq_in = 0; tif.e2m_valid = 0;
        tick(3);
        n_checks++;
        if (tif.irq_pending !== 4'b0 || tif.busy !== 1'b0) begin
            n_fail++; $display("FAIL irq_drop: got pending=%b busy=%b want 0000 0", tif.irq_pending, tif.busy);
        end
    endtask

    task automatic test_exc_vs_irq;
        tif.irq_in = 4'b0001; tif.irq_en = 4'hF; tif.interrupt_en = 1; tif.e2m_valid = 0;
        tick(3);
        n_checks++;
        if (tif.irq_pending !== 4'b0001 || tif.trap !== 1'b0) begin
            n_fail++; $display("FAIL both_wait: got pending=%b trap=%b want 0001 0", tif.irq_pending, tif.trap);
        end
        tif.e2m_valid = 1; tif.exc_req = 6'b001001; tif.e2m_pc = 32'h200;
        tick(1);
        n_checks++;
        if (tif.trap !== 1'b1 || tif.trap_cause !== 32'd3 || tif.is_interrupt !== 1'b0 || tif.irq_pending[0] !== 1'b1) begin
            n_fail++; $display("FAIL both_exc_first: got trap=%b cause=%h int=%b pend0=%b want 1 3 0 1",
                               tif.trap, tif.trap_cause, tif.is_interrupt, tif.irq_pending[0]);
        end
        tif.exc_req = 0;
        tick(1);
        n_checks++;
        if (tif.trap !== 1'b0 || tif.busy !== 1'b1 || tif.trap_cause !== 32'd3) begin
            n_fail++; $display("FAIL both_hold_ignores_irq: got trap=%b busy=%b cause=%h want 0 1 3", tif.trap, tif.busy, tif.trap_cause);
        end
        tick(1);
        n_checks++;
        if (tif.trap !== 1'b0 || tif.busy !== 1'b0) begin
            n_fail++; $display("FAIL both_idle: got trap=%b busy=%b want 0 0", tif.trap, tif.busy);
        end
        tick(1);
        n_checks++;
        if (tif.trap !== 1'b1 || tif.trap_cause !== 32'h80000010 || tif.trap_target !== 32'h840 || tif.is_interrupt !== 1'b1) begin
            n_fail++; $display("FAIL both_irq_after: got trap=%b cause=%h tgt=%h int=%b want 1 80000010 840 1",
                               tif.trap, tif.trap_cause, tif.trap_target, tif.is_interrupt);
        end
        tif.irq_in = 0; tif.e2m_valid = 0;
        tick(3);
    endtask

    task automatic test_irq_mask;
        tif.irq_in = 4'b0010; tif.irq_en = 4'b1101; tif.interrupt_en = 1; tif.e2m_valid = 1;
        tif.mtvec_mode = 2'b00; tif.e2m_pc = 32'h500;
        tick(4);
        n_checks++;
        if (tif.trap !== 1'b0 || tif.busy !== 1'b0) begin
            n_fail++; $display("FAIL mask_line: got trap=%b busy=%b want 0 0", tif.trap, tif.busy);
        end
        tif.irq_en = 4'hF; tif.interrupt_en = 0;
        tick(3);
        n_checks++;
        if (tif.trap !== 1'b0 || tif.busy !== 1'b0 || tif.irq_pending !== 4'b0010) begin
            n_fail++; $display("FAIL mask_global: got trap=%b busy=%b pending=%b want 0 0 0010", tif.trap, tif.busy, tif.irq_pending);
        end
        tif.interrupt_en = 1;
        tick(1);
        n_checks++;
        if (tif.trap !== 1'b1 || tif.trap_cause !== 32'h80000011 || tif.trap_target !== 32'h800) begin
            n_fail++; $display("FAIL mask_release: got trap=%b cause=%h tgt=%h want 1 80000011 800", tif.trap, tif.trap_cause, tif.trap_target);
        end
        tif.irq_in = 0; tif.e2m_valid = 0;
        tick(3);
    endtask

    task automatic test_vector_wrap;
        tif.mtvec_base = 32'hFFFF_FFF0; tif.mtvec_mode = 2'b01;
        tif.irq_in = 4'b0001; tif.irq_en = 4'hF; tif.interrupt_en = 1; tif.e2m_valid = 1;
        tick(3);
        n_checks++;
        if (tif.trap !== 1'b1 || tif.trap_target !== 32'h30) begin
            n_fail++; $display("FAIL vec_wrap: got trap=%b tgt=%h want 1 30", tif.trap, tif.trap_target);
        end
        tif.irq_in = 0; tif.e2m_valid = 0;
        tick(3);
        tif.mtvec_mode = 2'b11; tif.irq_in = 4'b0100; tif.e2m_valid = 1;
        tick(3);
        n_checks++;
        if (tif.trap !== 1'b1 || tif.trap_cause !== 32'h80000012 || tif.trap_target !== 32'hFFFF_FFF0) begin
            n_fail++; $display("FAIL vec_mode3_direct: got trap=%b cause=%h tgt=%h want 1 80000012 fffffff0",
                               tif.trap, tif.trap_cause, tif.trap_target);
        end
        tif.irq_in = 0; tif.e2m_valid = 0; tif.mtvec_base = 32'h800; tif.mtvec_mode = 2'b01;
        tick(3);
    endtask

    task automatic test_valid_gate;
        tif.exc_req = 6'b010000; tif.e2m_valid = 0; tif.e2m_pc = 32'h600;
        for (int i = 0; i < 3; i++) begin
            tick(1);
            n_checks++;
            if (tif.trap !== 1'b0 || tif.busy !== 1'b0) begin
                n_fail++; $display("FAIL valid_gate[%0d]: got trap=%b busy=%b want 0 0", i, tif.trap, tif.busy);
            end
        end
        tif.e2m_valid = 1;
        tick(1);
        n_checks++;
        if (tif.trap !== 1'b1 || tif.trap_cause !== 32'd4 || tif.trap_pc !== 32'h600) begin
            n_fail++; $display("FAIL valid_take: got trap=%b cause=%h pc=%h want 1 4 600", tif.trap, tif.trap_cause, tif.trap_pc);
        end
        tif.exc_req = 0; tif.e2m_valid = 0;
        tick(2);
    endtask

    task automatic test_hold_reset;
        tif.e2m_valid = 1; tif.exc_req = 6'b001000; tif.e2m_pc = 32'h300; tif.mtvec_mode = 2'b10;
        tick(1);
        n_checks++;
        if (tif.trap !== 1'b1 || tif.trap_cause !== 32'd11 || tif.trap_target !== 32'h800) begin
            n_fail++; $display("FAIL hold_take: got trap=%b cause=%h tgt=%h want 1 b 800", tif.trap, tif.trap_cause, tif.trap_target);
        end
        tif.exc_req = 6'b010000;
        tick(1);
        n_checks++;
        if (tif.trap !== 1'b0 || tif.busy !== 1'b1 || tif.trap_cause !== 32'd11 || flushes !== 4'hF) begin
            n_fail++; $display("FAIL hold_ignore: got trap=%b busy=%b cause=%h flush=%b want 0 1 b 1111",
                               tif.trap, tif.busy, tif.trap_cause, flushes);
        end
        RST = 1'b1;
        #1;
        n_checks++;
        if ({tif.trap, tif.busy, tif.is_interrupt, flushes} !== 7'b0 ||
            {tif.trap_pc, tif.trap_cause, tif.trap_target} !== 96'b0) begin
            n_fail++; $display("FAIL hold_async_reset: got ctrl=%b pc=%h cause=%h tgt=%h want all 0",
                               {tif.trap, tif.busy, tif.is_interrupt, flushes}, tif.trap_pc, tif.trap_cause, tif.trap_target);
        end
        tif.exc_req = 0; tif.e2m_valid = 0; tif.mtvec_mode = 2'b01;
        tick(1);
        RST = 1'b0;
        tick(1);
        n_checks++;
        if (tif.trap !== 1'b0 || tif.busy !== 1'b0) begin
            n_fail++; $display("FAIL hold_after_reset: got trap=%b busy=%b want 0 0", tif.trap, tif.busy);
        end
    endtask

`ifdef TRAP_CONTROLLER_IRQ_EDGE_EN
    task automatic test_irq_edge;
        tif.irq_en = 4'hF; tif.interrupt_en = 1; tif.e2m_valid = 0; tif.mtvec_mode = 2'b01;
        tif.irq_in = 4'b0100;
        tick(1);
        tif.irq_in = 4'b0000;
        tick(5);
        n_checks++;
        if (tif.irq_pending !== 4'b0100) begin
            n_fail++; $display("FAIL edge_sticky: got pending=%b want 0100", tif.irq_pending);
        end
        tif.e2m_valid = 1;
        tick(1);
        n_checks++;
        if (tif.trap !== 1'b1 || tif.trap_cause !== 32'h80000012) begin
            n_fail++; $display("FAIL edge_take: got trap=%b cause=%h want 1 80000012", tif.trap, tif.trap_cause);
        end
        tif.e2m_valid = 0;
        tick(1);
        n_checks++;
        if (tif.irq_pending !== 4'b0000) begin
            n_fail++; $display("FAIL edge_clear: got pending=%b want 0000", tif.irq_pending);
        end
        tick(2);
    endtask
`endif

    initial begin
        test_reset;
        test_exception;
        test_exc_priority;
        test_irq_level;
        test_exc_vs_irq;
        test_irq_mask;
        test_vector_wrap;
        test_valid_gate;
`ifdef TRAP_CONTROLLER_IRQ_EDGE_EN
        test_irq_edge;
`endif
        test_hold_reset;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no end of test want finish before 200000");
        $fatal(1);
    end

endmodule
